// File: rtl/pc_ras_unit.sv
// Program counter with 4-way next-PC select, sticky halt latch and a circular
// return-address stack that records pc_plus on JAL and unwinds on JR $31.
module pc_ras_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] PC_INIT   = '0,
    parameter int               INC       = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WEN,
    input  logic             halt,
    input  logic [1:0]       npc_sel,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pco,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             halted
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_pc;
    logic             r_halted;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];

    logic             w_adv;
    logic             w_empty;
    logic             w_full;
    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_npc;
    logic [PW-1:0]    w_ptr_up;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_do_repl;

    assign w_adv     = WEN && !r_halted && !halt;
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(RAS_DEPTH));
    assign w_pc_plus = r_pc + WIDTH'(INC);
    assign w_ptr_up  = r_ptr + PW'(1);

    // Push+pop on an empty stack degenerates to a plain push.
    assign w_do_push = w_adv && ras_push && (!ras_pop || w_empty);
    assign w_do_pop  = w_adv && ras_pop && !ras_push && !w_empty;
    assign w_do_repl = w_adv && ras_push && ras_pop && !w_empty;

    always_comb begin
        w_npc = w_pc_plus;
        case (npc_sel)
            2'b01:   w_npc = branch_taken ? branch_target : w_pc_plus;
            2'b10:   w_npc = jump_target;
            2'b11:   w_npc = jr_target;
            default: w_npc = w_pc_plus;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc     <= PC_INIT;
            r_halted <= 1'b0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
        end else begin
            if (WEN && halt && !r_halted) r_halted <= 1'b1;
            if (w_adv) r_pc <= w_npc;
            // A full stack wraps onto the oldest slot; count saturates.
            if (w_do_push) begin
                r_ptr           <= w_ptr_up;
                r_ras[w_ptr_up] <= w_pc_plus;
                if (!w_full) r_cnt <= r_cnt + CW'(1);
            end
            if (w_do_pop) begin
                r_ptr <= r_ptr - PW'(1);
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_do_repl) r_ras[r_ptr] <= w_pc_plus;
        end
    end

    assign pco       = r_pc;
    assign pc_plus   = w_pc_plus;
    assign ras_top   = w_empty ? '0 : r_ras[r_ptr];
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign halted    = r_halted;
endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit: a behavioural model (queue-based stack)
// predicts outputs per edge; directed scenarios also check literal values.
module tb_pc_ras_unit;
    localparam int W = 32;
    localparam int D = 4;

    logic         CLK = 1'b0;
    logic         RST, WEN, halt, branch_taken, ras_push, ras_pop;
    logic [1:0]   npc_sel;
    logic [W-1:0] branch_target, jump_target, jr_target;
    logic [W-1:0] pco, pc_plus, ras_top;
    logic         ras_empty, ras_full, halted;

    pc_ras_unit #(.WIDTH(W), .PC_INIT('0), .INC(4), .RAS_DEPTH(D)) dut (
        .CLK(CLK), .RST(RST), .WEN(WEN), .halt(halt), .npc_sel(npc_sel),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_target(jump_target), .jr_target(jr_target),
        .ras_push(ras_push), .ras_pop(ras_pop), .pco(pco), .pc_plus(pc_plus),
        .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full),
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] top;
        logic         empty;
        logic         full;
        logic         hlt;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_stk[$];
    logic [W-1:0] m_pc = '0;
    logic         m_halted = 1'b0;
    int           total = 0;
    int           bad = 0;

    // Apply one cycle of stimulus, advance the model, queue its prediction.
    task automatic drive(input logic rst, wen, hlt, input logic [1:0] sel,
                         input logic tk, psh, pp,
                         input logic [W-1:0] bt, jt, jrt);
        logic [W-1:0] pcp;
        exp_t e;
        RST = rst; WEN = wen; halt = hlt; npc_sel = sel; branch_taken = tk;
        ras_push = psh; ras_pop = pp;
        branch_target = bt; jump_target = jt; jr_target = jrt;
        pcp = m_pc + 32'd4;
        if (rst) begin
            m_pc = '0; m_halted = 1'b0; m_stk.delete();
        end else if (wen && !m_halted && hlt) begin
            m_halted = 1'b1;
        end else if (wen && !m_halted) begin
            case (sel)
                2'b00: m_pc = pcp;
                2'b01: m_pc = tk ? bt : pcp;
                2'b10: m_pc = jt;
                default: m_pc = jrt;
            endcase
            if (psh && pp && m_stk.size() > 0) m_stk[m_stk.size()-1] = pcp;
            else if (psh) begin
                m_stk.push_back(pcp);
                if (m_stk.size() > D) void'(m_stk.pop_front());
            end else if (pp && m_stk.size() > 0) void'(m_stk.pop_back());
        end
        e.pc = m_pc;
        e.top = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
        e.empty = (m_stk.size() == 0);
        e.full = (m_stk.size() == D);
        e.hlt = m_halted;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        drive(1, 0, 0, 2'b00, 0, 0, 0, '0, '0, '0);
        e = sb.pop_front();
        o = '{pco, ras_top, ras_empty, ras_full, halted};
        total++;
        if (o !== e || pco !== 32'h0 || ras_empty !== 1'b1) begin
            bad++;
            $display("FAIL reset: got pc=%h top=%h e=%b f=%b h=%b want pc=%h top=%h e=%b f=%b h=%b",
                     o.pc, o.top, o.empty, o.full, o.hlt, e.pc, e.top, e.empty, e.full, e.hlt);
        end
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, 1, 0, 2'b00, 0, 0, 0, '0, '0, '0);
            e = sb.pop_front();
            o = '{pco, ras_top, ras_empty, ras_full, halted};
            total++;
            if (o !== e || pco !== ((i == 3) ? 32'h0 : 32'(4 * (i + 1)))) begin
                bad++;
                $display("FAIL seq_rst[%0d]: got pc=%h want pc=%h (model %h)", i, o.pc,
                         (i == 3) ? 32'h0 : 32'(4 * (i + 1)), e.pc);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e, o;
        logic [W-1:0] want [5] = '{32'h10, 32'h14, 32'h40, 32'h100, 32'h2C};
        logic [1:0]   sel  [5] = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b11};
        logic         tk   [5] = '{0, 0, 1, 0, 0};
        logic [W-1:0] jt   [5] = '{32'h10, 32'h0, 32'h0, 32'h100, 32'h0};
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, sel[i], tk[i], 0, 0, 32'h40, jt[i], 32'h2C);
            e = sb.pop_front();
            o = '{pco, ras_top, ras_empty, ras_full, halted};
            total++;
            if (o !== e || pco !== want[i]) begin
                bad++;
                $display("FAIL branch[%0d]: got pc=%h want pc=%h (model %h)", i, o.pc, want[i], e.pc);
            end
        end
    endtask

    task automatic test_stall_wrap();
        exp_t e, o;
        for (int i = 0; i < 7; i++) begin
            if (i < 2) drive(0, 1, 0, 2'b00, 0, 1, 0, '0, '0, '0);
            else if (i < 5) drive(0, 0, 0, 2'b10, 0, 1, i == 4, '0, 32'h500, '0);
            else if (i == 5) drive(0, 1, 0, 2'b10, 0, 0, 0, '0, 32'hFFFF_FFFC, '0);
            else drive(0, 1, 0, 2'b00, 0, 0, 0, '0, '0, '0);
            e = sb.pop_front();
            o = '{pco, ras_top, ras_empty, ras_full, halted};
            total++;
            if (o !== e || (i == 6 && pco !== 32'h0) || (i == 4 && pco !== 32'h34)) begin
                bad++;
                $display("FAIL stall_wrap[%0d]: got pc=%h top=%h want pc=%h top=%h",
                         i, o.pc, o.top, e.pc, e.top);
            end
        end
    endtask

    task automatic test_halt();
        exp_t e, o;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: drive(1, 0, 0, 2'b00, 0, 0, 0, '0, '0, '0);
                1: drive(0, 1, 0, 2'b10, 0, 0, 0, '0, 32'h20, '0);
                2: drive(0, 1, 1, 2'b10, 0, 1, 0, '0, 32'h99, '0);
                7: drive(1, 1, 1, 2'b10, 0, 1, 0, '0, 32'h77, '0);
                default: drive(0, i[0], i == 4, 2'b10, 0, 1, i == 5, '0, 32'h300, '0);
            endcase
            e = sb.pop_front();
            o = '{pco, ras_top, ras_empty, ras_full, halted};
            total++;
            if (o !== e || (i >= 2 && i < 7 && (pco !== 32'h20 || halted !== 1'b1 || ras_empty !== 1'b1))
                        || (i == 7 && (pco !== 32'h0 || halted !== 1'b0))) begin
                bad++;
                $display("FAIL halt[%0d]: got pc=%h h=%b e=%b want pc=%h h=%b e=%b",
                         i, o.pc, o.hlt, o.empty, e.pc, e.hlt, e.empty);
            end
        end
    endtask

    task automatic test_ras_overflow();
        exp_t e, o;
        logic [W-1:0] want_top [10] = '{32'h0, 32'h4, 32'h14, 32'h24, 32'h34,
                                        32'h44, 32'h34, 32'h24, 32'h14, 32'h0};
        for (int i = 0; i < 10; i++) begin
            if (i == 0) drive(1, 0, 0, 2'b00, 0, 0, 0, '0, '0, '0);
            else if (i <= 5) drive(0, 1, 0, 2'b10, 0, 1, 0, '0, 32'(16 * i), '0);
            else drive(0, 1, 0, 2'b00, 0, 0, 1, '0, '0, '0);
            e = sb.pop_front();
            o = '{pco, ras_top, ras_empty, ras_full, halted};
            total++;
            if (o !== e || ras_top !== want_top[i] || (i == 5 && ras_full !== 1'b1)
                        || (i == 9 && ras_empty !== 1'b1)) begin
                bad++;
                $display("FAIL ras_ovf[%0d]: got top=%h e=%b f=%b want top=%h e=%b f=%b",
                         i, o.top, o.empty, o.full, want_top[i], e.empty, e.full);
            end
        end
    endtask

    task automatic test_ras_edge();
        exp_t e, o;
        logic [W-1:0] want_top [10] = '{32'h0, 32'h0, 32'h4, 32'h44, 32'h84,
                                        32'h4, 32'h0, 32'h0, 32'h4, 32'h0};
        for (int i = 0; i < 10; i++) begin
            case (i)
                0, 7: drive(1, 0, 0, 2'b00, 0, 0, 0, '0, '0, '0);
                1: drive(0, 1, 0, 2'b10, 0, 0, 1, '0, 32'h0, '0);
                2: drive(0, 1, 0, 2'b10, 0, 1, 0, '0, 32'h40, '0);
                3: drive(0, 1, 0, 2'b10, 0, 1, 0, '0, 32'h80, '0);
                4: drive(0, 1, 0, 2'b00, 0, 1, 1, '0, '0, '0);
                8: drive(0, 1, 0, 2'b00, 0, 1, 1, '0, '0, '0);
                default: drive(0, 1, 0, 2'b00, 0, 0, 1, '0, '0, '0);
            endcase
            e = sb.pop_front();
            o = '{pco, ras_top, ras_empty, ras_full, halted};
            total++;
            if (o !== e || ras_top !== want_top[i]) begin
                bad++;
                $display("FAIL ras_edge[%0d]: got top=%h e=%b f=%b want top=%h e=%b f=%b",
                         i, o.top, o.empty, o.full, want_top[i], e.empty, e.full);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, $urandom);
            e = sb.pop_front();
            o = '{pco, ras_top, ras_empty, ras_full, halted};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rand[%0d]: got pc=%h top=%h e=%b f=%b h=%b want pc=%h top=%h e=%b f=%b h=%b",
                         i, o.pc, o.top, o.empty, o.full, o.hlt, e.pc, e.top, e.empty, e.full, e.hlt);
            end
        end
    endtask

    initial begin
        RST = 1; WEN = 0; halt = 0; npc_sel = 2'b00; branch_taken = 0;
        ras_push = 0; ras_pop = 0; branch_target = '0; jump_target = '0; jr_target = '0;
        @(negedge CLK);
        test_reset();
        test_branch();
        test_stall_wrap();
        test_halt();
        test_ras_overflow();
        test_ras_edge();
        drive(1, 0, 0, 2'b00, 0, 0, 0, '0, '0, '0);
        void'(sb.pop_front());
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised next-generation program counter for the MIPS datapath.
- Holds the PC register and computes next-PC from a 4-way select: sequential, conditional branch, jump, or jump-register.
- Adds a sticky halt latch and a small return-address stack (RAS) that is pushed on JAL and popped on JR $31.
- Sits between fetch and the control/decode logic; pco drives the instruction-memory address.

Parameters:
- WIDTH, 32: PC and target width in bits.
- PC_INIT, 0: PC value after reset.
- INC, 4: sequential increment in bytes.
- RAS_DEPTH, 4: number of return-address entries; must be a power of two, ≥ 2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- WEN  input  1  advance enable; 0 means stall, and all state holds.
- halt  input  1  halt request from decode.
- npc_sel  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 jr.
- branch_taken  input  1  branch condition result; used only when npc_sel = 01.
- branch_target  input  WIDTH  branch destination.
- jump_target  input  WIDTH  J/JAL destination.
- jr_target  input  WIDTH  JR destination (register value).
- ras_push  input  1  push pc_plus onto the RAS (JAL).
- ras_pop  input  1  pop the RAS (JR $31).
- pco  output  WIDTH  current PC.
- pc_plus  output  WIDTH  pco + INC, combinational, modulo 2^WIDTH.
- ras_top  output  WIDTH  top-of-stack value; 0 when empty.
- ras_empty  output  1  RAS holds no entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- halted  output  1  sticky halt flag.

Behaviour:
- Reset (RST = 1 at an edge) overrides everything, including mid-stall and mid-halt:
  - pco = PC_INIT, halted = 0.
  - RAS count = 0, all entries = 0.
  - ras_top = 0, ras_empty = 1, ras_full = 0.
- Define adv = WEN && !halted && !halt. State changes only on an edge with adv = 1, except the halt latch.
- Halt latch:
  - At an edge with WEN = 1 && halt = 1 && !halted, halted becomes 1.
  - On that edge pco holds (the halt instruction stays at pco) and RAS push/pop are ignored.
  - Once halted = 1, all inputs except RST are ignored; halted clears only on reset.
  - halt with WEN = 0 has no effect that cycle.
- Next-PC when adv = 1, one-cycle latency (new pco visible the cycle after the edge):
  - 00: pco + INC.
  - 01: branch_target if branch_taken, else pco + INC.
  - 10: jump_target.
  - 11: jr_target.
- Width and arithmetic rules:
  - Addition wraps modulo 2^WIDTH; for example, pco = 2^WIDTH − 4 with seq gives 0.
  - No alignment check; targets pass through unmodified.
- RAS as a circular buffer with pointer and count, applied on an edge with adv = 1:
  - Push only: writes pc_plus at top+1 and count++. If full, the oldest entry is overwritten, count stays RAS_DEPTH, and ras_full stays 1.
  - Pop only: if count > 0, count-- and top moves down. If empty, no-op.
  - Push and pop together: top entry replaced by pc_plus, count unchanged. If empty, behaves as push only.
  - Without adv, push/pop are ignored.
- ras_top is combinational from the registered top entry and is 0 whenever count = 0.
- ras_empty = (count == 0); ras_full = (count == RAS_DEPTH).
- The RAS does not steer pco. Control uses ras_top to form jr_target for prediction; this block only stores the values.

Test Plan:
- Reset, then 3 cycles with WEN = 1 and seq → pco = 0, 4, 8, 12; assert RST mid-run → pco = 0 on the next cycle.
- Branch selects: at pco = 0x10, npc_sel = 01, taken = 0 → 0x14; taken = 1, target 0x40 → 0x40; npc_sel = 10, target 0x100 → 0x100; npc_sel = 11, jr_target 0x2C → 0x2C.
- Stall and wrap: WEN = 0 for 3 cycles → pco constant and RAS unchanged; pco = 0xFFFFFFFC with seq → 0x00000000.
- Halt: halt = 1 at pco = 0x20 → halted = 1 and pco stays 0x20; further jumps, pushes and WEN toggles change nothing; RST → pco = PC_INIT, halted = 0.
- RAS fill and overflow: DEPTH = 4, push at pco = 0x0, 0x10, 0x20, 0x30, 0x40 → ras_full = 1, ras_top = 0x44; 4 pops → tops 0x34, 0x24, 0x14, then empty; the oldest value 0x04 was lost.
- RAS edge cases:
  - Pop when empty → ras_empty stays 1, ras_top = 0.
  - Push and pop together with count = 2 at pco = 0x80 → count stays 2, ras_top = 0x84.
  - Push and pop together on an empty stack → count = 1.
